bram_heap_sift_up: RTL and testbench

BRAM_HEAP_SIFT_UP -- requirements
Module: bram_heap_sift_up

---
 rtl/bram_heap_sift_up_pkg.sv | 31 +++
 rtl/bram_heap_sift_up_ram.sv | 35 +++
 rtl/bram_heap_sift_up.sv | 158 +++++++++++++++
 tb/tb_bram_heap_sift_up.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_heap_sift_up_pkg.sv
// Shared heap package: tree geometry helpers and the sift-up controller states.
package bram_heap_sift_up_pkg;

  // Sift-up controller states
  //   state       | meaning
  //   IDLE        | ready for an insert; o_ready high
  //   WRITE_LEAF  | new value written at the next free leaf
  //   READ_PARENT | parent address presented to the BRAM
  //   WAIT        | BRAM read latency
  //   COMPARE     | new value vs parent; swap or finish
  //   DONE        | o_done pulse, back to IDLE
  typedef enum logic [2:0] {
    IDLE,
    WRITE_LEAF,
    READ_PARENT,
    WAIT,
    COMPARE,
    DONE
  } heap_state_e;

  // Number of nodes in the smallest complete binary tree holding qsize entries.
  function automatic int unsigned heap_nodes_needed(input int unsigned qsize);
    return (32'd1 << $clog2(qsize + 1)) - 32'd1;
  endfunction

  // Parent of node n in the flat array layout; the root maps onto itself.
  function automatic int unsigned heap_parent(input int unsigned n);
    return (n == 0) ? 32'd0 : (n - 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/bram_heap_sift_up_ram.sv
// True-dual-port read-first BRAM: both ports share one clock; a port reads the
// old contents of its address in the same cycle it writes.
module rams_tdp_rf_rf #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 7,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [WIDTH-1:0]  dia,
  output logic [WIDTH-1:0]  doa,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [WIDTH-1:0]  dib,
  output logic [WIDTH-1:0]  dob
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports: registered read-first output, optional write
  always_ff @(posedge clk) begin
    if (ena) begin
      doa <= mem[addra];
      if (wea) mem[addra] <= dia;
    end
    if (enb) begin
      dob <= mem[addrb];
      if (web) mem[addrb] <= dib;
    end
  end

endmodule

// File: rtl/bram_heap_sift_up.sv
// Max-heap insert engine: appends a value at the first free leaf and sifts it
// up through a dual-port BRAM, one parent compare every three cycles.
module bram_heap_sift_up
  import bram_heap_sift_up_pkg::*;
#(
  parameter int QUEUE_SIZE = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            i_wrt,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_ready,
  output logic                            o_done,
  output logic                            o_overflow,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_size,
  output logic [DATA_WIDTH-1:0]           o_top
);

  localparam int SW           = $clog2(QUEUE_SIZE + 1);
  localparam int NODES_NEEDED = int'(heap_nodes_needed(QUEUE_SIZE));

  heap_state_e           state_q, state_d;
  logic [SW-1:0]         size_q, size_d;
  logic [SW-1:0]         cur_idx_q, cur_idx_d;
  logic [DATA_WIDTH-1:0] cur_val_q, cur_val_d;
  logic [DATA_WIDTH-1:0] top_q, top_d;
  logic                  overflow_q, overflow_d;

  logic [SW-1:0]         parent_idx;
  logic                  full, accept, reject, swap;

  logic                  en_a, we_a, en_b, we_b;
  logic [SW-1:0]         addr_a, addr_b;
  logic [DATA_WIDTH-1:0] din_a, din_b, parent_val, ram_doa_unused;

  assign parent_idx = SW'(heap_parent(32'(cur_idx_q)));
  assign full       = (size_q == SW'(QUEUE_SIZE));
  assign accept     = (state_q == IDLE) && i_wrt && !full;
  assign reject     = (state_q == IDLE) && i_wrt && full;
  // Equal values stay put, so the compare is strict.
  assign swap       = (state_q == COMPARE) && (cur_val_q > parent_val);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = WRITE_LEAF;
      WRITE_LEAF:  state_d = (cur_idx_q == '0) ? DONE : READ_PARENT;
      READ_PARENT: state_d = WAIT;
      WAIT:        state_d = COMPARE;
      COMPARE: begin
        if (swap) state_d = (parent_idx == '0) ? DONE : READ_PARENT;
        else      state_d = DONE;
      end
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Outputs and BRAM port controls; port A owns cur_idx, port B owns its parent
  always_comb begin
    o_ready = (state_q == IDLE);
    o_done  = (state_q == DONE);
    en_a    = 1'b0;
    we_a    = 1'b0;
    en_b    = 1'b0;
    we_b    = 1'b0;
    addr_a  = cur_idx_q;
    addr_b  = parent_idx;
    din_a   = cur_val_q;
    din_b   = cur_val_q;
    case (state_q)
      WRITE_LEAF: begin
        en_a = 1'b1;
        we_a = 1'b1;
      end
      READ_PARENT: en_b = 1'b1;
      COMPARE: begin
        if (swap) begin
          en_a  = 1'b1;
          we_a  = 1'b1;
          din_a = parent_val;
          en_b  = 1'b1;
          we_b  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: size, travelling index/value, root mirror, overflow pulse
  always_comb begin
    size_d     = size_q;
    cur_idx_d  = cur_idx_q;
    cur_val_d  = cur_val_q;
    top_d      = top_q;
    overflow_d = reject;
    if (accept) begin
      size_d    = size_q + SW'(1);
      cur_idx_d = size_q;
      cur_val_d = i_data;
    end
    if (swap) cur_idx_d = parent_idx;
    if ((state_q == WRITE_LEAF) && (cur_idx_q == '0)) top_d = cur_val_q;
    if (swap && (parent_idx == '0)) top_d = cur_val_q;
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      size_q     <= '0;
      cur_idx_q  <= '0;
      cur_val_q  <= '0;
      top_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      size_q     <= size_d;
      cur_idx_q  <= cur_idx_d;
      cur_val_q  <= cur_val_d;
      top_q      <= top_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_overflow = overflow_q;
  assign o_full     = full;
  assign o_empty    = (size_q == '0);
  assign o_size     = size_q;
  assign o_top      = top_q;

  rams_tdp_rf_rf #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (NODES_NEEDED),
    .ADDR_W(SW)
  ) u_ram (
    .clk  (CLK),
    .ena  (en_a),
    .wea  (we_a),
    .addra(addr_a),
    .dia  (din_a),
    .doa  (ram_doa_unused),
    .enb  (en_b),
    .web  (we_b),
    .addrb(addr_b),
    .dib  (din_b),
    .dob  (parent_val)
  );

endmodule

// File: tb/tb_bram_heap_sift_up.sv
// Bench for bram_heap_sift_up: directed scenarios plus random inserts checked
// against an array-based max-heap model.
module tb_bram_heap_sift_up;

  localparam int QS = 7;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          i_wrt = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ready, o_done, o_overflow, o_full, o_empty;
  logic [2:0]    o_size;
  logic [DW-1:0] o_top;

  int checks = 0;
  int errors = 0;

  int unsigned mheap [0:15];
  int          msize = 0;

  bram_heap_sift_up #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_wrt     (i_wrt),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_done    (o_done),
    .o_overflow(o_overflow),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_size    (o_size),
    .o_top     (o_top)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_top();
    return (msize > 0) ? mheap[0] : 32'd0;
  endfunction

  // Reference insert: place at the end, bubble up while strictly larger.
  // Returns the number of parent compares performed.
  task automatic model_insert(input int unsigned v, output int ncmp);
    int idx;
    int p;
    int unsigned t;
    idx = msize;
    ncmp = 0;
    mheap[idx] = v;
    msize++;
    while (idx > 0) begin
      p = (idx - 1) / 2;
      ncmp++;
      if (mheap[idx] > mheap[p]) begin
        t = mheap[p];
        mheap[p] = mheap[idx];
        mheap[idx] = t;
        idx = p;
      end else begin
        break;
      end
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_top"}, o_top, model_top());
    chk({tag, "_size"}, o_size, msize);
    chk({tag, "_empty"}, o_empty, msize == 0);
    chk({tag, "_full"}, o_full, msize == QS);
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < msize; i++)
      chk($sformatf("%s_node%0d", tag, i), dut.u_ram.mem[i], mheap[i]);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_size", o_size, 0);
    chk("rst_top", o_top, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovf", o_overflow, 0);
    RST = 1'b0;
    msize = 0;
    @(posedge CLK); #1;
  endtask

  // Issue one insert; optionally keep i_wrt high (with changing data) while busy.
  task automatic do_insert(input logic [DW-1:0] v, input bit hold_in);
    int ncmp;
    int lat;
    int wait_cyc;
    bit hold;
    int unsigned old_top;
    hold = hold_in && (msize < QS);
    wait_cyc = 0;
    while (!o_ready && wait_cyc < 50) begin
      @(posedge CLK); #1;
      wait_cyc++;
    end
    chk("ready_wait", o_ready, 1);
    old_top = model_top();
    i_wrt = 1'b1;
    i_data = v;
    @(posedge CLK); #1;
    if (msize == QS) begin
      i_wrt = 1'b0;
      chk("ovf_pulse", o_overflow, 1);
      chk("ovf_ready", o_ready, 1);
      chk("ovf_size", o_size, QS);
      chk("ovf_top", o_top, old_top);
      @(posedge CLK); #1;
      chk("ovf_once", o_overflow, 0);
      check_status("ovf_after");
      check_array("ovf_arr");
      return;
    end
    if (!hold) i_wrt = 1'b0;
    model_insert(32'(v), ncmp);
    chk("acc_size", o_size, msize);
    chk("acc_busy", o_ready, 0);
    chk("acc_ovf", o_overflow, 0);
    lat = 1;
    while (!o_done && lat < 64) begin
      if (hold) i_data = DW'($urandom);
      @(posedge CLK); #1;
      lat++;
    end
    i_wrt = 1'b0;
    chk("latency", lat, 2 + 3 * ncmp);
    check_status("done");
    check_array("arr");
    @(posedge CLK); #1;
    chk("done_once", o_done, 0);
    chk("back_idle", o_ready, 1);
    chk("idle_size", o_size, msize);
  endtask

  initial begin
    // Reset values while RST is held from time zero
    #1;
    chk("init_ready", o_ready, 1);
    chk("init_empty", o_empty, 1);
    chk("init_size", o_size, 0);
    chk("init_top", o_top, 0);
    do_reset();

    // Single insert into an empty queue
    do_insert(16'd5, 1'b0);
    chk("one_top", o_top, 5);
    chk("one_size", o_size, 1);

    // 3, 9, 7: one swap for 9, then [9,3,7]
    do_reset();
    do_insert(16'd3, 1'b0);
    do_insert(16'd9, 1'b0);
    do_insert(16'd7, 1'b0);
    chk("s397_top", o_top, 9);

    // 1..4: 4 climbs two levels
    do_reset();
    do_insert(16'd1, 1'b0);
    do_insert(16'd2, 1'b0);
    do_insert(16'd3, 1'b0);
    do_insert(16'd4, 1'b0);
    chk("s1234_top", o_top, 4);

    // Equal values never swap
    do_reset();
    do_insert(16'd6, 1'b0);
    do_insert(16'd6, 1'b0);
    chk("eq_top", o_top, 6);

    // Fill to capacity (some inserts hold i_wrt while busy), then overflow
    do_reset();
    do_insert(16'd10, 1'b0);
    do_insert(16'd20, 1'b1);
    do_insert(16'd15, 1'b0);
    do_insert(16'd30, 1'b1);
    do_insert(16'd5, 1'b0);
    do_insert(16'd25, 1'b1);
    do_insert(16'd40, 1'b0);
    chk("fill_full", o_full, 1);
    do_insert(16'd100, 1'b0);
    chk("fill_top", o_top, 40);

    // Reset while the insert is in WAIT
    do_reset();
    do_insert(16'd2, 1'b0);
    i_wrt = 1'b1;
    i_data = 16'd5;
    @(posedge CLK); #1;
    i_wrt = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_empty", o_empty, 1);
    chk("midrst_size", o_size, 0);
    chk("midrst_top", o_top, 0);
    chk("midrst_done", o_done, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    msize = 0;
    @(posedge CLK); #1;
    check_status("midrst_after");
    do_insert(16'd8, 1'b0);
    chk("midrst_top8", o_top, 8);

    // Random rounds, small value range so ties are common
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int n = 0; n < 9; n++)
        do_insert(DW'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
